// File: rtl/msk_rx_pkg.sv
// Shared types and constants for the MSK RX acquisition sequencer.
// Lock-detector counter widths are derived from each target inside msk_lock_det.
package msk_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TIM_ACQ  = 3'd1,
        ST_CFO_CRS  = 3'd2,
        ST_CFO_FINE = 3'd3,
        ST_LOCKED   = 3'd4
    } acq_state_t;

    localparam int WERR        = 18;
    localparam int EW          = 24;
    localparam int TED_THR     = 2048;
    localparam int PD_THR      = 65536;
    localparam int TIM_LOCK_N  = 64;
    localparam int PD_LOCK_N   = 128;
    localparam int LOSS_N      = 32;
    localparam int TIMEOUT_SYM = 4096;

    // Counter width able to hold 0..n inclusive, so a count can sit at its target.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int SYM_CW = cnt_w(TIMEOUT_SYM);

endpackage

// File: rtl/msk_lock_det.sv
// Error-magnitude qualifier: |err| < THR is good; tracks good and bad runs.
// good_o/bad_o fire combinationally on the strobe that completes a run of N / BAD_N.
module msk_lock_det
    import msk_rx_pkg::*;
#(
    parameter int W     = 18,
    parameter int THR   = 2048,
    parameter int N     = 64,
    parameter int BAD_N = N
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                val,
    input  logic signed [W-1:0] err,
    output logic                good_o,
    output logic                bad_o
);

    localparam int GW = cnt_w(N);
    localparam int BW = cnt_w(BAD_N);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};

    logic [W-1:0]  mag;
    logic          is_good;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;

    // Full-width magnitude; the most-negative code has no positive twin, so clamp it.
    always_comb begin
        mag = err;
        if (err == MOST_NEG)
            mag = MAX_POS;
        else if (err[W-1])
            mag = -err;
    end

    assign is_good = mag < W'(THR);
    assign good_o  = val &  is_good & (good_cnt >= GW'(N - 1));
    assign bad_o   = val & ~is_good & (bad_cnt  >= BW'(BAD_N - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (clr) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (val) begin
            if (is_good) begin
                good_cnt <= (good_cnt == GW'(N)) ? good_cnt : good_cnt + 1'b1;
                bad_cnt  <= '0;
            end else begin
                good_cnt <= '0;
                bad_cnt  <= (bad_cnt == BW'(BAD_N)) ? bad_cnt : bad_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/msk_rx_acq_ctrl.sv
// MSK RX acquisition sequencer: timing lock -> coarse CFO -> fine carrier lock,
// with per-state symbol timeout, loss-of-lock re-acquisition and a retry counter.
module msk_rx_acq_ctrl
    import msk_rx_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable_i,
    input  logic                   sym_valid_i,
    input  logic signed [WERR-1:0] ted_err_i,
    input  logic                   ted_err_val_i,
    input  logic                   cfo_done_i,
    input  logic signed [EW-1:0]   pd_err_i,
    input  logic                   pd_err_val_i,
    output logic                   tim_loop_en_o,
    output logic                   loop_rst_o,
    output logic                   cfo_en_o,
    output logic                   nco_load_o,
    output logic                   fine_en_o,
    output logic                   lock_o,
    output logic [2:0]             state_o,
    output logic [7:0]             retry_cnt_o
);

    acq_state_t        state_q, state_d;
    logic [SYM_CW-1:0] sym_cnt;
    logic [7:0]        retry_cnt;
    logic              loop_rst_q, nco_load_q;
    logic              rst_pulse, ld_pulse, retry, entry, tmo, in_acq;
    logic              ted_lock, ted_bad_unused, pd_lock, pd_loss;

    msk_lock_det #(.W(WERR), .THR(TED_THR), .N(TIM_LOCK_N)) u_ted_det (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (entry),
        .val    (ted_err_val_i),
        .err    (ted_err_i),
        .good_o (ted_lock),
        .bad_o  (ted_bad_unused)
    );

    // The PD bad-run output doubles as the loss-of-lock detector.
    msk_lock_det #(.W(EW), .THR(PD_THR), .N(PD_LOCK_N), .BAD_N(LOSS_N)) u_pd_det (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (entry),
        .val    (pd_err_val_i),
        .err    (pd_err_i),
        .good_o (pd_lock),
        .bad_o  (pd_loss)
    );

    assign in_acq = (state_q == ST_TIM_ACQ) || (state_q == ST_CFO_CRS) || (state_q == ST_CFO_FINE);
    assign tmo    = in_acq && sym_valid_i && (sym_cnt == SYM_CW'(TIMEOUT_SYM - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Priority inside each branch: lock/done first, timeout last.
    always_comb begin
        state_d   = state_q;
        rst_pulse = 1'b0;
        ld_pulse  = 1'b0;
        retry     = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_TIM_ACQ;
                    rst_pulse = 1'b1;
                end
                ST_TIM_ACQ: begin
                    if (ted_lock) state_d = ST_CFO_CRS;
                    else if (tmo) retry = 1'b1;
                end
                ST_CFO_CRS: begin
                    if (cfo_done_i) begin
                        state_d  = ST_CFO_FINE;
                        ld_pulse = 1'b1;
                    end else if (tmo) retry = 1'b1;
                end
                ST_CFO_FINE: begin
                    if (pd_lock)  state_d = ST_LOCKED;
                    else if (tmo) retry = 1'b1;
                end
                ST_LOCKED: begin
                    if (pd_loss) retry = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
            if (retry) begin
                state_d   = ST_TIM_ACQ;
                rst_pulse = 1'b1;
            end
        end
    end

    // A timeout re-enters TIM_ACQ from itself, which still counts as an entry.
    assign entry = (state_d != state_q) || retry;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_cnt    <= '0;
            retry_cnt  <= '0;
            loop_rst_q <= 1'b0;
            nco_load_q <= 1'b0;
        end else begin
            loop_rst_q <= rst_pulse;
            nco_load_q <= ld_pulse;
            if (entry)                    sym_cnt <= '0;
            else if (in_acq && sym_valid_i) sym_cnt <= sym_cnt + 1'b1;
            if (retry && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 1'b1;
        end
    end

    always_comb begin
        tim_loop_en_o = 1'b0;
        cfo_en_o      = 1'b0;
        fine_en_o     = 1'b0;
        lock_o        = 1'b0;
        case (state_q)
            ST_TIM_ACQ:  tim_loop_en_o = 1'b1;
            ST_CFO_CRS:  begin tim_loop_en_o = 1'b1; cfo_en_o = 1'b1; end
            ST_CFO_FINE: begin tim_loop_en_o = 1'b1; fine_en_o = 1'b1; end
            ST_LOCKED:   begin tim_loop_en_o = 1'b1; fine_en_o = 1'b1; lock_o = 1'b1; end
            default: ;
        endcase
    end

    assign loop_rst_o  = loop_rst_q;
    assign nco_load_o  = nco_load_q;
    assign state_o     = state_q;
    assign retry_cnt_o = retry_cnt;

endmodule
